// File: rtl/mem_req_pkg.sv
// mem_req_pkg: shared state, size and lsV encodings for the data-side request path
package mem_req_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, HOLD = 2'd3} state_t;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [3:0] LS_BYTE = 4'b0001;
  localparam logic [3:0] LS_HALF = 4'b0011;
  localparam logic [3:0] LS_WORD = 4'b1111;
  function automatic logic misaligned(input logic [3:0] ls, input logic [1:0] a);
    return (ls == LS_HALF && a[0]) || (ls == LS_WORD && a != 2'b00);
  endfunction
endpackage

// File: rtl/mem_req_pack.sv
// mem_req_pack: maps size mask, low address and store data to bus size, strobes, replicated data and alignment faults
module mem_req_pack
  import mem_req_pkg::*;
(
  input  logic [3:0]  ls_v,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic        load,
  input  logic        store,
  output logic [1:0]  size,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic        adel,
  output logic        ades
);
  logic mis;
  // field encoding and misalignment detection
  always_comb begin
    mis = misaligned(ls_v, addr_lo);
    size = {ls_v[3], ls_v[1] & ~ls_v[3]};
    wstrb = store ? ls_v << addr_lo : 4'b0000;
    wdata_rep = ls_v == LS_BYTE ? {4{wdata[7:0]}} : ls_v == LS_HALF ? {2{wdata[15:0]}} : wdata;
    adel = mis & load;
    ades = mis & store;
  end
endmodule

// File: rtl/mem_req.sv
// mem_req: issues one data-side load/store at a time and buffers the raw returned word for writeback
module mem_req
  import mem_req_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic        mem_loadX,
  input  logic [3:0]  mem_lsV,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_flush,
  output logic        mem_ready,
  output logic        mem_adel,
  output logic        mem_ades,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  input  logic        wb_allowin,
  output logic        wb_valid,
  output logic        wb_load,
  output logic        wb_loadX,
  output logic [3:0]  wb_lsV,
  output logic [1:0]  wb_data_addr,
  output logic [31:0] wb_rdata_raw
);
  state_t state, state_n;
  logic discard, drop, accept, ret, adel_c, ades_c;
  logic [1:0] size_c;
  logic [3:0] wstrb_c;
  logic [31:0] wdata_c;

  mem_req_pack u_pack (
    .ls_v(mem_lsV), .addr_lo(mem_addr[1:0]), .wdata(mem_wdata),
    .load(mem_load), .store(mem_store),
    .size(size_c), .wstrb(wstrb_c), .wdata_rep(wdata_c),
    .adel(adel_c), .ades(ades_c)
  );

  assign mem_adel = mem_valid & adel_c;
  assign mem_ades = mem_valid & ades_c;

  // next state, handshake strobes and state-decoded outputs
  always_comb begin
    drop = discard | mem_flush;
    accept = state == IDLE && mem_valid && (mem_load | mem_store) && !mem_flush && !(adel_c | ades_c);
    ret = (state == REQ && data_addr_ok && data_data_ok) || (state == WAIT && data_data_ok);
    mem_ready = state == IDLE && !mem_flush;
    data_req = state == REQ;
    wb_valid = state == HOLD;
    state_n = state;
    case (state)
      IDLE: state_n = accept ? REQ : IDLE;
      REQ:  state_n = !data_addr_ok ? REQ : !data_data_ok ? WAIT : drop ? IDLE : HOLD;
      WAIT: state_n = !data_data_ok ? WAIT : drop ? IDLE : HOLD;
      HOLD: state_n = (mem_flush | wb_allowin) ? IDLE : HOLD;
    endcase
  end

  // state register; discard remembers a flush until the bus transaction drains
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      discard <= 1'b0;
    end else begin
      state <= state_n;
      discard <= state_n != IDLE && drop;
    end

  // request fields registered at acceptance so the bus sees stable values
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data_wr <= 1'b0;
      data_size <= 2'd0;
      data_addr <= 32'd0;
      data_wstrb <= 4'd0;
      data_wdata <= 32'd0;
    end else if (accept) begin
      data_wr <= mem_store;
      data_size <= size_c;
      data_addr <= mem_addr;
      data_wstrb <= wstrb_c;
      data_wdata <= wdata_c;
    end

  // writeback attributes captured at acceptance, raw word captured on return
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wb_load <= 1'b0;
      wb_loadX <= 1'b0;
      wb_lsV <= 4'd0;
      wb_data_addr <= 2'd0;
      wb_rdata_raw <= 32'd0;
    end else begin
      if (accept) begin
        wb_load <= mem_load;
        wb_loadX <= mem_loadX;
        wb_lsV <= mem_lsV;
        wb_data_addr <= mem_addr[1:0];
      end
      if (ret) wb_rdata_raw <= data_wr ? 32'd0 : data_rdata;
    end
endmodule

// File: tb/tb_mem_req.sv
// tb_mem_req: directed scoreboard bench for mem_req
module tb_mem_req;
  import mem_req_pkg::*;
  logic clk = 0, rst = 0;
  logic mem_valid = 0, mem_load = 0, mem_store = 0, mem_loadX = 0, mem_flush = 0;
  logic [3:0] mem_lsV = 0;
  logic [31:0] mem_addr = 0, mem_wdata = 0, data_rdata = 0;
  logic data_addr_ok = 0, data_data_ok = 0, wb_allowin = 1;
  logic mem_ready, mem_adel, mem_ades, data_req, data_wr, wb_valid, wb_load, wb_loadX;
  logic [1:0] data_size, wb_data_addr;
  logic [3:0] data_wstrb, wb_lsV;
  logic [31:0] data_addr, data_wdata, wb_rdata_raw;

  typedef struct packed {logic wr; logic [1:0] size; logic [31:0] addr; logic [3:0] wstrb; logic [31:0] wdata;} req_t;
  typedef struct packed {logic load; logic loadx; logic [3:0] lsv; logic [1:0] a; logic [31:0] rdata;} wb_t;
  req_t req_q[$];
  wb_t wb_q[$];
  int checks = 0, errors = 0;

  mem_req dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_load(mem_load), .mem_store(mem_store),
    .mem_loadX(mem_loadX), .mem_lsV(mem_lsV), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_flush(mem_flush), .mem_ready(mem_ready), .mem_adel(mem_adel), .mem_ades(mem_ades),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .wb_allowin(wb_allowin),
    .wb_valid(wb_valid), .wb_load(wb_load), .wb_loadX(wb_loadX), .wb_lsV(wb_lsV),
    .wb_data_addr(wb_data_addr), .wb_rdata_raw(wb_rdata_raw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic lx, input logic [3:0] ls,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_valid = 1; mem_load = ld; mem_store = st; mem_loadX = lx; mem_lsV = ls; mem_addr = a; mem_wdata = wd;
    #1;
    chk("accept_ready", mem_ready, 1);
    chk("accept_noexc", {mem_adel, mem_ades}, 0);
    tick;
    mem_valid = 0; mem_load = 0; mem_store = 0; mem_loadX = 0;
  endtask

  // monitor: bus requests checked at addr_ok, results checked every cycle wb_valid is up
  always @(negedge clk) if (!rst) begin
    if (data_req && data_addr_ok) begin
      if (req_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL bus_req_unexpected got addr %0h want none", data_addr);
      end else chk("bus_req", {data_wr, data_size, data_addr, data_wstrb, data_wdata}, req_q.pop_front());
    end
    if (wb_valid) begin
      if (wb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wb_unexpected got rdata %0h want no wb_valid", wb_rdata_raw);
      end else begin
        chk("wb_result", {wb_load, wb_loadX, wb_lsV, wb_data_addr, wb_rdata_raw}, wb_q[0]);
        if (wb_allowin) void'(wb_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    #1 rst = 1;
    #2 chk("reset_outs", {data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata, wb_valid,
                          wb_load, wb_loadX, wb_lsV, wb_data_addr, wb_rdata_raw}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    tick;
    // sb at 0x1003
    req_q.push_back('{1'b1, SZ_BYTE, 32'h1003, 4'b1000, 32'hA5A5A5A5});
    wb_q.push_back('{1'b0, 1'b0, LS_BYTE, 2'd3, 32'h0});
    issue(0, 1, 0, LS_BYTE, 32'h1003, 32'h000000A5);
    chk("sb_req_c1", data_req, 1);
    data_addr_ok = 1; tick; data_addr_ok = 0;
    chk("sb_nowb_c2", wb_valid, 0);
    data_data_ok = 1; data_rdata = 32'h11111111; tick; data_data_ok = 0;
    chk("sb_wb_c3", wb_valid, 1);
    tick;
    chk("sb_idle", {mem_ready, wb_valid, data_req}, 3'b100);
    // lw at 0x2000, addr_ok and data_ok together
    req_q.push_back('{1'b0, SZ_WORD, 32'h2000, 4'b0000, 32'h0});
    wb_q.push_back('{1'b1, 1'b0, LS_WORD, 2'd0, 32'hDEADBEEF});
    issue(1, 0, 0, LS_WORD, 32'h2000, 32'h0);
    chk("lw_req_c1", data_req, 1);
    data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'hDEADBEEF; tick;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    chk("lw_wb_c2", wb_valid, 1);
    chk("lw_rdata", wb_rdata_raw, 32'hDEADBEEF);
    tick;
    chk("lw_idle", mem_ready, 1);
    // misaligned lh and sw, then flush blocking acceptance in IDLE
    mem_valid = 1; mem_load = 1; mem_lsV = LS_HALF; mem_addr = 32'h2001;
    #1 chk("lh_adel", {mem_adel, mem_ades, mem_ready}, 3'b101);
    tick;
    chk("lh_noreq", data_req, 0);
    mem_load = 0; mem_store = 1; mem_lsV = LS_WORD; mem_addr = 32'h2002;
    #1 chk("sw_ades", {mem_adel, mem_ades, mem_ready}, 3'b011);
    tick;
    chk("sw_noreq", data_req, 0);
    mem_store = 0; mem_load = 1; mem_addr = 32'h2004; mem_flush = 1;
    #1 chk("flush_idle_ready", mem_ready, 0);
    tick;
    chk("flush_idle_noreq", data_req, 0);
    mem_valid = 0; mem_load = 0; mem_flush = 0;
    // lw held by writeback for 3 cycles
    req_q.push_back('{1'b0, SZ_WORD, 32'h3004, 4'b0000, 32'h0});
    wb_q.push_back('{1'b1, 1'b0, LS_WORD, 2'd0, 32'h12345678});
    issue(1, 0, 0, LS_WORD, 32'h3004, 32'h0);
    data_addr_ok = 1; tick; data_addr_ok = 0;
    data_data_ok = 1; data_rdata = 32'h12345678; wb_allowin = 0; tick;
    data_data_ok = 0; data_rdata = 0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", wb_valid, 1);
      chk("hold_rdata", wb_rdata_raw, 32'h12345678);
      tick;
    end
    chk("hold_release_valid", wb_valid, 1);
    wb_allowin = 1; tick;
    chk("hold_idle", {mem_ready, wb_valid}, 2'b10);
    // sh flushed one cycle after acceptance
    req_q.push_back('{1'b1, SZ_HALF, 32'h4002, 4'b1100, 32'hBEEFBEEF});
    issue(0, 1, 0, LS_HALF, 32'h4002, 32'h0000BEEF);
    chk("flush_req_c1", data_req, 1);
    mem_flush = 1; tick; mem_flush = 0;
    chk("flush_req_held", {data_req, mem_ready}, 2'b10);
    data_addr_ok = 1; tick; data_addr_ok = 0;
    chk("flush_wait", {data_req, wb_valid}, 2'b00);
    data_data_ok = 1; tick; data_data_ok = 0;
    chk("flush_nowb", {mem_ready, wb_valid}, 2'b10);
    tick;
    chk("flush_nowb_late", wb_valid, 0);
    // reset while waiting for data
    req_q.push_back('{1'b0, SZ_WORD, 32'h5000, 4'b0000, 32'h0});
    issue(1, 0, 1, LS_WORD, 32'h5000, 32'h0);
    data_addr_ok = 1; tick; data_addr_ok = 0;
    rst = 1;
    #1 chk("rst_wait_outs", {data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata, wb_valid,
                             wb_load, wb_loadX, wb_lsV, wb_data_addr, wb_rdata_raw}, 0);
    tick;
    rst = 0;
    tick;
    // signed lb after reset
    req_q.push_back('{1'b0, SZ_BYTE, 32'h6001, 4'b0000, 32'h0});
    wb_q.push_back('{1'b1, 1'b1, LS_BYTE, 2'd1, 32'hCAFEF00D});
    issue(1, 0, 1, LS_BYTE, 32'h6001, 32'h0);
    chk("lb_req_c1", data_req, 1);
    data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'hCAFEF00D; tick;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    chk("lb_wb_c2", wb_valid, 1);
    tick;
    chk("queues_empty", req_q.size() + wb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_req.md
# mem_req

Data-side memory request issuer; the store/issue counterpart of the writeback load-extraction stage. Takes one load or store per transaction from the MEM stage, checks alignment, builds the SRAM-like bus request (byte strobes, lane-replicated write data, size), tracks the single outstanding transaction through addr_ok/data_ok, and buffers the raw returned word until writeback accepts it. Sits between the MEM pipeline stage and the data-side SRAM-to-AXI bridge.

## Interface
- No parameters; data and address widths are fixed at 32.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mem_valid  in  1  MEM stage presents an access
- mem_load  in  1  access is a load
- mem_store  in  1  access is a store; mem_load and mem_store are never both 1
- mem_loadX  in  1  signed load; passed through to writeback
- mem_lsV  in  4  size mask: 4'b0001 byte, 4'b0011 half, 4'b1111 word
- mem_addr  in  32  byte address
- mem_wdata  in  32  store data, right-justified
- mem_flush  in  1  exception/ERET flush; discards the in-flight result
- mem_ready  out  1  access accepted this cycle
- mem_adel / mem_ades  out  1  misaligned load / store, combinational
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  request address
- data_wstrb  out  4  byte strobes
- data_wdata  out  32  lane-replicated write data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  data/response returned
- data_rdata  in  32  raw read word
- wb_allowin  in  1  writeback accepts this cycle
- wb_valid  out  1  result available
- wb_load, wb_loadX  out  1  captured attributes
- wb_lsV  out  4  captured size mask
- wb_data_addr  out  2  captured mem_addr[1:0]
- wb_rdata_raw  out  32  unshifted returned word (0 for stores)

## Operation
- States: IDLE, REQ, WAIT, HOLD. One transaction outstanding at most.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0, raises mem_adel (load) or mem_ades (store). No request is issued; mem_ready=1 so the access is consumed.
- IDLE: mem_ready = !mem_flush. An aligned mem_valid with (mem_load|mem_store) and !mem_flush registers the request and moves to REQ.
- REQ: data_req=1 with registered fields; the request is never withdrawn. On data_addr_ok, move to WAIT.
- WAIT: on data_data_ok, capture data_rdata (stores capture 0), then move to HOLD; on discard, move to IDLE without presenting a result.
- HOLD: wb_valid=1. On wb_allowin, move to IDLE.
- Field encoding:
  - data_wstrb = lsV << addr[1:0], and 0 when data_wr=0.
  - data_size = {lsV[3], lsV[1] & !lsV[3]}.
  - data_wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word as-is.
  - data_addr is the full address, unmasked.
- Flush: mem_flush in REQ/WAIT sets a discard flag. The bus transaction still completes, but wb_valid is never raised for it; the flag clears on return to IDLE. mem_flush in HOLD drops the result and moves to IDLE. mem_flush in IDLE blocks acceptance.
- mem_ready=0 in every state other than IDLE.

## Timing
- Reset: state IDLE, discard 0. data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata, wb_valid, wb_load, wb_loadX, wb_lsV, wb_data_addr, wb_rdata_raw all 0.
- Acceptance at edge N gives data_req=1 from cycle N+1; all request fields are register outputs.
- data_addr_ok and data_data_ok may assert in the same cycle. In that case REQ goes directly to HOLD (or to IDLE if discarding).
- Data returned at edge M gives wb_valid=1 from cycle M+1. wb_rdata_raw stays stable while wb_valid=1 && !wb_allowin.
- Minimum load-to-result: 2 cycles after acceptance, with addr_ok and data_ok both in the first REQ cycle.
- Reset mid-transaction returns to IDLE immediately; the bus side is reset with this block.

## Structure
- Shared package holds the state encoding (IDLE=0, REQ=1, WAIT=2, HOLD=3), the size codes, and the lsV encodings. Writeback uses the same lsV encodings.
- One natural sub-module: mem_req_pack. It is purely combinational and maps (lsV, addr[1:0], wdata) to (size, wstrb, wdata, adel/ades).

## Test plan
- sb: addr 0x1003, wdata 0x000000A5, addr_ok in cycle 1, data_ok in cycle 2 -> data_wstrb 4'b1000, data_wdata 0xA5A5A5A5, data_size 0; wb_valid in cycle 3.
- lw: addr 0x2000, addr_ok and data_ok both in cycle 1, rdata 0xDEADBEEF -> wb_rdata_raw 0xDEADBEEF with wb_valid in cycle 2.
- lh: addr 0x2001 -> mem_adel=1, data_req stays 0, mem_ready=1. sw at 0x2002 -> mem_ades=1.
- lw with wb_allowin=0 for 3 cycles after the return -> wb_valid and wb_rdata_raw held for 3 cycles; IDLE and mem_ready=1 in the cycle after wb_allowin=1.
- mem_flush one cycle after a sh is accepted -> data_req held until addr_ok, data_ok consumed, wb_valid never 1.
- rst asserted while in WAIT -> all outputs 0 in the same cycle; a new access is accepted after rst deasserts.
